topk_tracker: RTL and testbench
===============================

// Module: topk_tracker
// PURPOSE
//   Streaming top-K tracker: keeps the K largest unsigned samples seen since reset/clear,
//   sorted in descending order. Any rank can be read back. Successor to the fixed
//   largest/second-largest tracker: K, width, valid qualifier, sync clear, fill count.
//   Sits on a sample stream in the monitor/stat path; the output is read by a CSR or next stage.
// PARAMETERS
//   DATA_WIDTH  32  sample width; values compared as unsigned
//   K           4   number of ranks tracked; legal range 2..64
//   IDX_W       $clog2(K)    localparam; rd_idx width
//   CNT_W       $clog2(K+1)  localparam; count width
// PORTS
//   clk        in   1           clock; all state updates on the rising edge
//   resetn     in   1           asynchronous active-low reset
//   clr        in   1           synchronous clear of all slots
//   din_valid  in   1           din is a sample this cycle
//   din        in   DATA_WIDTH  sample
//   rd_idx     in   IDX_W       rank to read; 0 = largest
//   dout       out  DATA_WIDTH  value of slot rd_idx; 0 if the slot is empty
//   dout_valid out  1           slot rd_idx holds a sample
//   dout_2nd   out  DATA_WIDTH  fixed rank-1 tap (second largest); 0 if empty
//   count      out  CNT_W       filled slots; saturates at K
// BEHAVIOUR
//   - State: slot[0..K-1] (DATA_WIDTH) and vld[0..K-1]. Invariants: vld is a thermometer
//     code (vld[i] implies vld[i-1]); valid slots are non-increasing.
//   - Reset (resetn=0, async): all slots 0, vld 0, count 0. dout/dout_2nd read 0 and dout_valid reads 0.
//   - Insert (din_valid=1, clr=0): p = lowest i with !vld[i] or din > slot[i] (strict compare).
//     Ties go after existing equal values. If p<K: slot[p+1..K-1] <= slot[p..K-2],
//     slot[p] <= din, and vld shifts the same way. slot[K-1] drops out when all slots are full.
//     If no such p exists (din <= slot[K-1], all full), there is no change.
//   - Single-cycle insert; a new sample can be accepted every cycle. The result is visible on
//     outputs in the cycle after the accepting edge.
//   - count: +1 per accepted insert while count<K; holds at K.
//   - Reads: dout/dout_valid/dout_2nd are combinational reads of the registered state
//     (no added latency). If rd_idx >= K (non-power-of-2 K): dout=0, dout_valid=0.
//   - clr=1, din_valid=0: the next state equals the reset state.
//   - clr=1, din_valid=1: clear and restart. Next state is slot[0]=din, vld[0]=1, count=1.
//   - resetn asserted mid-stream: state clears immediately. The first sample after release
//     lands in slot 0.
//   - No backpressure: every din_valid sample is evaluated and never stalled.
// CONFIGURATION
//   TOPK_UNIQUE_EN defined: a sample equal to any valid slot is discarded (no shift,
//     count unchanged), so slots hold distinct values.
//   TOPK_UNIQUE_EN undefined (default): duplicates occupy separate slots per the tie rule.
// STRUCTURE
//   topk_pkg: TOPK_K_MIN=2 and TOPK_K_MAX=64 constants, defaults for DATA_WIDTH and K.
//     Also a count_t width helper function; elaboration asserts K range.
//   Sub-module topk_slice: one per rank, generated K times. Inputs: own/upper slot and
//     vld, din. It computes gt_i = !vld | din>slot and eq_i. Its next-state mux chooses:
//     hold / take din (gt_i & !gt_{i-1}) / take upper (gt_{i-1}). gt_{-1}=0.
//   The top level holds count, clr priority, the rd_idx mux, and the UNIQUE_EN
//   OR-reduction of eq_i.
// TESTING
//   1 Reset, then K=4, din 5,9,3,7 -> ranks 0..3 = 9,7,5,3; count=4; dout_2nd=7.
//   2 Full array {9,7,5,3}, din 8 -> {9,8,7,5}. Then din 2 -> unchanged; count stays 4.
//   3 Partial: only din 6 accepted -> rd_idx=0: 6/valid. rd_idx=1: 0/dout_valid=0. dout_2nd=0.
//   4 {9,7,5,3}, clr with din_valid=1, din=4 -> {4,-,-,-}, count=1. clr alone -> count=0.
//   5 Duplicates: din 7,7,7. Default -> {7,7,7,-}, count=3.
//     TOPK_UNIQUE_EN -> {7,-,-,-}, count=1.
//   6 resetn pulsed low mid-stream between clk edges -> outputs 0 immediately, no clk edge needed;
//     din_valid gaps cause no change; back-to-back inserts every cycle are checked
//     against a sorted-queue reference model (random, DATA_WIDTH=8, K=5).

Source files
------------

// File: rtl/topk_pkg.sv
// rtl/topk_pkg.sv - shared constants and width helper for the top-K tracker
package topk_pkg;

  localparam int TOPK_K_MIN           = 2;
  localparam int TOPK_K_MAX           = 64;
  localparam int TOPK_DATA_WIDTH_DEF  = 32;
  localparam int TOPK_K_DEF           = 4;

  function automatic int count_w(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/topk_tracker_if.sv
// rtl/topk_tracker_if.sv - sample stream, rank read and status bundle for topk_tracker
interface topk_tracker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4
);
  localparam int IDX_W = $clog2(K);
  localparam int CNT_W = $clog2(K + 1);

  logic                  clr;
  logic                  din_valid;
  logic [DATA_WIDTH-1:0] din;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic [DATA_WIDTH-1:0] dout_2nd;
  logic [CNT_W-1:0]      count;

  modport master (
    output clr, din_valid, din, rd_idx,
    input  dout, dout_valid, dout_2nd, count
  );

  modport slave (
    input  clr, din_valid, din, rd_idx,
    output dout, dout_valid, dout_2nd, count
  );

endinterface

// File: rtl/topk_slice.sv
// rtl/topk_slice.sv - one rank of the sorted array: compare against din and pick hold/din/upper
module topk_slice #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  clr_take,
  input  logic                  ins,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] upper_slot,
  input  logic                  upper_vld,
  input  logic                  upper_gt,
  output logic [DATA_WIDTH-1:0] slot,
  output logic                  vld,
  output logic                  gt,
  output logic                  eq
);

  // Strict compare keeps a new sample behind existing equal values.
  assign gt = !vld || (din > slot);
  assign eq = vld && (din == slot);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot <= '0;
      vld  <= 1'b0;
    end else if (clr) begin
      slot <= clr_take ? din : '0;
      vld  <= clr_take;
    end else if (ins && upper_gt) begin
      slot <= upper_slot;
      vld  <= upper_vld;
    end else if (ins && gt) begin
      slot <= din;
      vld  <= 1'b1;
    end
  end

endmodule

// File: rtl/topk_tracker.sv
// rtl/topk_tracker.sv - streaming top-K tracker; TOPK_UNIQUE_EN discards samples equal to a held value
module topk_tracker
  import topk_pkg::*;
#(
  parameter int DATA_WIDTH = TOPK_DATA_WIDTH_DEF,
  parameter int K          = TOPK_K_DEF
) (
  input  logic           clk,
  input  logic           resetn,
  topk_tracker_if.slave  bus
);

  localparam int IDX_W = $clog2(K);
  localparam int CNT_W = count_w(K);

  if (K < TOPK_K_MIN || K > TOPK_K_MAX) begin : g_bad_k
    $error("topk_tracker: K out of range");
  end

  logic [DATA_WIDTH-1:0] slot     [K];
  logic [DATA_WIDTH-1:0] up_slot  [K];
  logic [K-1:0]          vld;
  logic [K-1:0]          up_vld;
  logic [K-1:0]          up_gt;
  logic [K-1:0]          gt;
  logic [K-1:0]          eq;
  logic                  dup;
  logic                  ins;
  logic [CNT_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_vld;

`ifdef TOPK_UNIQUE_EN
  assign dup = |eq;
`else
  logic unused_eq;
  assign unused_eq = |eq;
  assign dup       = 1'b0;
`endif

  assign ins = bus.din_valid && !dup;

  for (genvar i = 0; i < K; i++) begin : g_rank
    if (i == 0) begin : g_head
      assign up_slot[i] = '0;
      assign up_vld[i]  = 1'b0;
      assign up_gt[i]   = 1'b0;
    end else begin : g_body
      assign up_slot[i] = slot[i-1];
      assign up_vld[i]  = vld[i-1];
      assign up_gt[i]   = gt[i-1];
    end

    topk_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice (
      .clk        (clk),
      .resetn     (resetn),
      .clr        (bus.clr),
      .clr_take   ((i == 0) && bus.din_valid),
      .ins        (ins),
      .din        (bus.din),
      .upper_slot (up_slot[i]),
      .upper_vld  (up_vld[i]),
      .upper_gt   (up_gt[i]),
      .slot       (slot[i]),
      .vld        (vld[i]),
      .gt         (gt[i]),
      .eq         (eq[i])
    );
  end

  // gt[K-1] set means the sample found a home somewhere in the array.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (bus.clr) begin
      count_q <= CNT_W'(bus.din_valid);
    end else if (ins && gt[K-1] && (count_q != CNT_W'(K))) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_vld  = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (bus.rd_idx == IDX_W'(i)) begin
        rd_data = vld[i] ? slot[i] : '0;
        rd_vld  = vld[i];
      end
    end
  end

  assign bus.dout       = rd_data;
  assign bus.dout_valid = rd_vld;
  assign bus.dout_2nd   = vld[1] ? slot[1] : '0;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_topk_tracker.sv
// tb/tb_topk_tracker.sv - directed K=4 checks plus randomized K=5 run against a sorted-queue model
module tb_topk_tracker;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  topk_tracker_if #(.DATA_WIDTH(32), .K(4)) b4 ();
  topk_tracker_if #(.DATA_WIDTH(8),  .K(5)) b5 ();

  topk_tracker #(.DATA_WIDTH(32), .K(4)) u4 (.clk(clk), .resetn(resetn), .bus(b4));
  topk_tracker #(.DATA_WIDTH(8),  .K(5)) u5 (.clk(clk), .resetn(resetn), .bus(b5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push4(input int v);
    b4.din       = 32'(v);
    b4.din_valid = 1'b1;
    @(negedge clk);
    b4.din_valid = 1'b0;
  endtask

  task automatic clr4(input bit with_valid, input int v);
    b4.clr       = 1'b1;
    b4.din_valid = with_valid;
    b4.din       = 32'(v);
    @(negedge clk);
    b4.clr       = 1'b0;
    b4.din_valid = 1'b0;
  endtask

  // Expected contents listed largest first; n of them are valid.
  task automatic check4(input string tag, input int n, input int e0, input int e1,
                        input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      b4.rd_idx = 2'(i);
      #1;
      check($sformatf("%s_val%0d", tag, i), b4.dout, (i < n) ? e[i] : 0);
      check($sformatf("%s_vld%0d", tag, i), b4.dout_valid, (i < n) ? 1 : 0);
    end
    check({tag, "_cnt"}, b4.count, n);
    check({tag, "_2nd"}, b4.dout_2nd, (n > 1) ? e[1] : 0);
    b4.rd_idx = 2'd0;
  endtask

  int q5[$];
  int r_din, r_idx, r_exp;
  bit r_val, r_clr;

  task automatic model_ins(input int d);
`ifdef TOPK_UNIQUE_EN
    foreach (q5[i]) if (q5[i] == d) return;
`endif
    q5.push_back(d);
    q5.rsort();
    if (q5.size() > 5) void'(q5.pop_back());
  endtask

  task automatic check5(input string tag, input int idx);
    b5.rd_idx = 3'(idx);
    #1;
    r_exp = (idx < q5.size()) ? q5[idx] : 0;
    check({tag, "_val"}, b5.dout, r_exp);
    check({tag, "_vld"}, b5.dout_valid, (idx < q5.size()) ? 1 : 0);
    check({tag, "_cnt"}, b5.count, q5.size());
    check({tag, "_2nd"}, b5.dout_2nd, (q5.size() > 1) ? q5[1] : 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    b4.clr = 1'b0; b4.din_valid = 1'b0; b4.din = '0; b4.rd_idx = '0;
    b5.clr = 1'b0; b5.din_valid = 1'b0; b5.din = '0; b5.rd_idx = '0;
    #1;
    check4("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    push4(5); push4(9); push4(3); push4(7);
    check4("fill", 4, 9, 7, 5, 3);
    push4(8);
    check4("mid_ins", 4, 9, 8, 7, 5);
    push4(2);
    check4("below_min", 4, 9, 8, 7, 5);

    clr4(1'b0, 0);
    check4("clr_only", 0, 0, 0, 0, 0);
    push4(6);
    check4("partial", 1, 6, 0, 0, 0);

    clr4(1'b0, 0);
    push4(5); push4(9); push4(3); push4(7);
    check4("refill", 4, 9, 7, 5, 3);
    clr4(1'b1, 4);
    check4("clr_din", 1, 4, 0, 0, 0);
    clr4(1'b0, 0);
    check4("clr_again", 0, 0, 0, 0, 0);

    push4(7); push4(7); push4(7);
`ifdef TOPK_UNIQUE_EN
    check4("dup", 1, 7, 0, 0, 0);
`else
    check4("dup", 3, 7, 7, 7, 0);
`endif

    for (int n = 0; n < 300; n++) begin
      r_val = ($urandom_range(0, 9) < 7);
      r_clr = ($urandom_range(0, 29) == 0);
      r_din = $urandom_range(0, 40);
      b5.din_valid = r_val;
      b5.clr       = r_clr;
      b5.din       = 8'(r_din);
      if (r_clr) q5.delete();
      if (r_val) model_ins(r_din);
      @(negedge clk);
      b5.din_valid = 1'b0;
      b5.clr       = 1'b0;
      r_idx = $urandom_range(0, 7);
      check5($sformatf("rnd%0d", n), r_idx);
    end

    b5.din_valid = 1'b1;
    b5.din = 8'd100; model_ins(100);
    @(negedge clk);
    b5.din = 8'd50;  model_ins(50);
    @(negedge clk);
    b5.din_valid = 1'b0;
    check5("pre_rst", 1);

    #1;
    resetn = 1'b0;
    q5.delete();
    #1;
    check5("async_rst", 0);
    @(negedge clk);
    resetn = 1'b1;

    b5.din_valid = 1'b1;
    b5.din = 8'd77; model_ins(77);
    @(negedge clk);
    b5.din_valid = 1'b0;
    check5("post_rst", 0);
    @(negedge clk);
    @(negedge clk);
    check5("gap", 0);
    b5.din_valid = 1'b1;
    b5.din = 8'd200; model_ins(200);
    @(negedge clk);
    b5.din_valid = 1'b0;
    check5("after_gap0", 0);
    check5("after_gap1", 1);
    check5("idx_oob", 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
